// File: rtl/regslv_req_arbiter.sv
// Round-robin arbiter sharing one regslv request port among NUM_MST masters,
// with one outstanding transaction, ack timeout and late-ack accounting.
module regslv_req_arbiter #(
    parameter int                    NUM_MST    = 4,
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    TO_CYCLES  = 1024,
    parameter logic [DATA_WIDTH-1:0] ERR_RDATA  = 32'hDEAD_BEEF
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_MST-1:0]            m_req_vld,
    input  logic [NUM_MST-1:0]            m_wr_en,
    input  logic [NUM_MST-1:0]            m_rd_en,
    input  logic [NUM_MST*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MST*DATA_WIDTH-1:0] m_wr_data,
    output logic [NUM_MST-1:0]            m_ack_vld,
    output logic [DATA_WIDTH-1:0]         m_rd_data,
    output logic                          m_err,
    output logic                          s_req_vld,
    output logic                          s_wr_en,
    output logic                          s_rd_en,
    output logic [ADDR_WIDTH-1:0]         s_addr,
    output logic [DATA_WIDTH-1:0]         s_wr_data,
    input  logic                          s_ack_vld,
    input  logic [DATA_WIDTH-1:0]         s_rd_data,
    output logic                          busy,
    output logic [7:0]                    late_ack_cnt
);

    localparam int PTR_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
    localparam int CW    = PTR_W + 1;
    localparam int TMR_W = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]       state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] winner;
    logic [PTR_W-1:0] ptr_next;
    logic [TMR_W-1:0] timer;

    logic             grant_any;
    logic [PTR_W-1:0] grant_idx;
    logic [CW-1:0]    cand;

    // Scan from rr_ptr upward with wrap; the first requester found wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_MST; k++) begin
            cand = {1'b0, rr_ptr} + CW'(k);
            if (cand >= CW'(NUM_MST)) begin
                cand = cand - CW'(NUM_MST);
            end
            if (!grant_any && m_req_vld[cand[PTR_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[PTR_W-1:0];
            end
        end
    end

    assign ptr_next = (winner == PTR_W'(NUM_MST - 1)) ? '0 : winner + PTR_W'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            winner    <= '0;
            timer     <= '0;
            busy      <= 1'b0;
            s_req_vld <= 1'b0;
            s_wr_en   <= 1'b0;
            s_rd_en   <= 1'b0;
            s_addr    <= '0;
            s_wr_data <= '0;
            m_ack_vld <= '0;
            m_rd_data <= '0;
            m_err     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        winner    <= grant_idx;
                        s_wr_en   <= m_wr_en[grant_idx];
                        s_rd_en   <= m_rd_en[grant_idx];
                        s_addr    <= m_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        s_wr_data <= m_wr_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                        s_req_vld <= 1'b1;
                        timer     <= '0;
                        busy      <= 1'b1;
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    // A real ack takes priority over a timeout landing on the same edge.
                    if (s_ack_vld || (timer == TMR_W'(TO_CYCLES - 1))) begin
                        m_rd_data <= s_ack_vld ? s_rd_data : ERR_RDATA;
                        m_err     <= ~s_ack_vld;
                        m_ack_vld <= NUM_MST'(1) << winner;
                        s_req_vld <= 1'b0;
                        s_wr_en   <= 1'b0;
                        s_rd_en   <= 1'b0;
                        state     <= S_RESP;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                S_RESP: begin
                    m_ack_vld <= '0;
                    rr_ptr    <= ptr_next;
                    state     <= S_GAP;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            late_ack_cnt <= '0;
        end else if (s_ack_vld && (state != S_REQ) && (late_ack_cnt != 8'hFF)) begin
            late_ack_cnt <= late_ack_cnt + 8'd1;
        end
    end

endmodule
